// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph constants, FSM states and defaults for seg7 capture
package seg7_pkg;

    localparam int SETTLE_CYCLES_DEFAULT = 4;

    // Active-low segments, bit 6 = g down to bit 0 = a
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLING = 2'd1,
        HELD     = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - maps an active-low segment pattern back to its hex nibble
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       bad
);

    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (seg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - recovers digits and whole frames from a multiplexed 7-segment display bus
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  AN,
    input  logic [6:0]  Cnode,
    input  logic [7:0]  digit_en,
    output logic        live_valid,
    output logic [2:0]  live_sel,
    output logic [3:0]  live_digit,
    output logic        live_bad,
    output logic        frame_valid,
    output logic [31:0] frame_digits,
    output logic [7:0]  frame_bad
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

    logic [7:0]  an_q;
    logic [6:0]  cn_q;
    logic [7:0]  an_low;
    logic        sample_sel;
    logic [2:0]  sample_idx;
    logic        same;

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [7:0]  st_an, st_an_next;
    logic [6:0]  st_cn, st_cn_next;
    logic        accept;

    logic [3:0]  dec_nibble;
    logic        dec_bad;

    logic [31:0] work_digits, work_digits_next;
    logic [7:0]  work_bad, work_bad_next;
    logic [7:0]  seen, seen_next;
    logic        complete;

    seg7_decode u_decode (
        .seg    (cn_q),
        .nibble (dec_nibble),
        .bad    (dec_bad)
    );

    // A select is a sample with exactly one anode driven low
    always_comb begin
        an_low     = ~an_q;
        sample_sel = (an_low != 8'd0) && ((an_low & (an_low - 8'd1)) == 8'd0);
        sample_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (an_low[i]) sample_idx = 3'(i);
        end
        same = (an_q == st_an) && (cn_q == st_cn);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_SEL;
            cnt   <= 8'd0;
            st_an <= 8'd0;
            st_cn <= 7'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            st_an <= st_an_next;
            st_cn <= st_cn_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        st_an_next = st_an;
        st_cn_next = st_cn;
        accept     = 1'b0;
        case (state)
            WAIT_SEL: begin
                if (sample_sel) begin
                    state_next = SETTLING;
                    cnt_next   = 8'd1;
                    st_an_next = an_q;
                    st_cn_next = cn_q;
                end
            end
            SETTLING: begin
                if (!sample_sel) begin
                    state_next = WAIT_SEL;
                end else if (same) begin
                    cnt_next = cnt + 8'd1;
                    if (cnt_next == SETTLE_LAST) begin
                        accept     = 1'b1;
                        state_next = HELD;
                    end
                end else begin
                    cnt_next   = 8'd1;
                    st_an_next = an_q;
                    st_cn_next = cn_q;
                end
            end
            HELD: begin
                if (!sample_sel) begin
                    state_next = WAIT_SEL;
                end else if (!same) begin
                    state_next = SETTLING;
                    cnt_next   = 8'd1;
                    st_an_next = an_q;
                    st_cn_next = cn_q;
                end
            end
            default: state_next = WAIT_SEL;
        endcase
    end

    // A digit landing on the completion edge is folded into the latched frame
    always_comb begin
        work_digits_next = work_digits;
        work_bad_next    = work_bad;
        seen_next        = seen;
        if (accept) begin
            work_digits_next[4*sample_idx +: 4] = dec_nibble;
            work_bad_next[sample_idx]           = dec_bad;
            seen_next[sample_idx]               = 1'b1;
        end
        complete = (digit_en != 8'd0) && ((seen & digit_en) == digit_en);
        if (complete) seen_next = 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q         <= 8'd0;
            cn_q         <= 7'd0;
            work_digits  <= 32'd0;
            work_bad     <= 8'd0;
            seen         <= 8'd0;
            live_valid   <= 1'b0;
            live_sel     <= 3'd0;
            live_digit   <= 4'd0;
            live_bad     <= 1'b0;
            frame_valid  <= 1'b0;
            frame_digits <= 32'd0;
            frame_bad    <= 8'd0;
        end else begin
            an_q        <= AN;
            cn_q        <= Cnode;
            work_digits <= work_digits_next;
            work_bad    <= work_bad_next;
            seen        <= seen_next;
            live_valid  <= accept;
            live_sel    <= accept ? sample_idx : 3'd0;
            live_digit  <= accept ? dec_nibble : 4'd0;
            live_bad    <= accept ? dec_bad : 1'b0;
            frame_valid <= complete;
            if (complete) begin
                frame_digits <= work_digits_next;
                frame_bad    <= work_bad_next;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - table-driven and directed self-checking bench for seg7_capture
module tb_seg7_capture;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  AN;
    logic [6:0]  Cnode;
    logic [7:0]  digit_en;
    logic        live_valid;
    logic [2:0]  live_sel;
    logic [3:0]  live_digit;
    logic        live_bad;
    logic        frame_valid;
    logic [31:0] frame_digits;
    logic [7:0]  frame_bad;

    seg7_capture #(.SETTLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .AN           (AN),
        .Cnode        (Cnode),
        .digit_en     (digit_en),
        .live_valid   (live_valid),
        .live_sel     (live_sel),
        .live_digit   (live_digit),
        .live_bad     (live_bad),
        .frame_valid  (frame_valid),
        .frame_digits (frame_digits),
        .frame_bad    (frame_bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] cn;
        int         hold;
        int         pulses;
        logic [2:0] sel;
        logic [3:0] digit;
        logic       bad;
    } vec_t;

    vec_t vecs [21];

    int tests  = 0;
    int failed = 0;

    int          live_cnt  = 0;
    int          frame_cnt = 0;
    logic [7:0]  live_log [$];
    logic        last_bad;
    logic [31:0] last_frame_digits;
    logic [7:0]  last_frame_bad;

    always @(negedge clk) begin
        if (live_valid) begin
            live_cnt = live_cnt + 1;
            live_log.push_back({1'b0, live_sel, live_digit});
            last_bad = live_bad;
        end
        if (frame_valid) begin
            frame_cnt         = frame_cnt + 1;
            last_frame_digits = frame_digits;
            last_frame_bad    = frame_bad;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] an, input logic [6:0] cn, input int n);
        repeat (n) begin
            AN    = an;
            Cnode = cn;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(8'hff, 7'h7f, 2);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " live_valid"},   32'(live_valid),  32'd0);
        check({tag, " live_sel"},     32'(live_sel),    32'd0);
        check({tag, " live_digit"},   32'(live_digit),  32'd0);
        check({tag, " live_bad"},     32'(live_bad),    32'd0);
        check({tag, " frame_valid"},  32'(frame_valid), 32'd0);
        check({tag, " frame_digits"}, frame_digits,     32'd0);
        check({tag, " frame_bad"},    32'(frame_bad),   32'd0);
    endtask

    initial begin
        int lbase, fbase;

        vecs[0]  = '{8'hfe, 7'b1000000, 6, 1, 3'd0, 4'h0, 1'b0};
        vecs[1]  = '{8'hfd, 7'b1111001, 6, 1, 3'd1, 4'h1, 1'b0};
        vecs[2]  = '{8'hfb, 7'b0100100, 6, 1, 3'd2, 4'h2, 1'b0};
        vecs[3]  = '{8'hf7, 7'b0110000, 6, 1, 3'd3, 4'h3, 1'b0};
        vecs[4]  = '{8'hef, 7'b0011001, 6, 1, 3'd4, 4'h4, 1'b0};
        vecs[5]  = '{8'hdf, 7'b0010010, 6, 1, 3'd5, 4'h5, 1'b0};
        vecs[6]  = '{8'hbf, 7'b0000010, 6, 1, 3'd6, 4'h6, 1'b0};
        vecs[7]  = '{8'h7f, 7'b1111000, 6, 1, 3'd7, 4'h7, 1'b0};
        vecs[8]  = '{8'hfe, 7'b0000000, 6, 1, 3'd0, 4'h8, 1'b0};
        vecs[9]  = '{8'hfd, 7'b0010000, 6, 1, 3'd1, 4'h9, 1'b0};
        vecs[10] = '{8'hfb, 7'b0001000, 6, 1, 3'd2, 4'hA, 1'b0};
        vecs[11] = '{8'hf7, 7'b0000011, 6, 1, 3'd3, 4'hB, 1'b0};
        vecs[12] = '{8'hef, 7'b1000110, 6, 1, 3'd4, 4'hC, 1'b0};
        vecs[13] = '{8'hdf, 7'b0100001, 6, 1, 3'd5, 4'hD, 1'b0};
        vecs[14] = '{8'hbf, 7'b0000110, 6, 1, 3'd6, 4'hE, 1'b0};
        vecs[15] = '{8'h7f, 7'b0001110, 6, 1, 3'd7, 4'hF, 1'b0};
        vecs[16] = '{8'hfe, 7'b1111111, 8, 1, 3'd0, 4'h0, 1'b1};
        vecs[17] = '{8'hfd, 7'b0110000, 3, 0, 3'd0, 4'h0, 1'b0};
        vecs[18] = '{8'hfb, 7'b0011001, 20, 1, 3'd2, 4'h4, 1'b0};
        vecs[19] = '{8'hfc, 7'b0011001, 10, 0, 3'd0, 4'h0, 1'b0};
        vecs[20] = '{8'hff, 7'b0011001, 10, 0, 3'd0, 4'h0, 1'b0};

        rst      = 1'b1;
        AN       = 8'hff;
        Cnode    = 7'h7f;
        digit_en = 8'h00;
        @(negedge clk);
        drive(8'hff, 7'h7f, 2);
        rst = 1'b0;
        check_all_zero("reset");
        check("reset state", 32'(dut.state), 32'(WAIT_SEL));

        // Glyph table with frames disabled; every record ends in blanking
        fbase = frame_cnt;
        for (int i = 0; i < 21; i++) begin
            lbase = live_cnt;
            drive(vecs[i].an, vecs[i].cn, vecs[i].hold);
            drive(8'hff, 7'h7f, 3);
            #1;
            check($sformatf("vec%0d pulses", i), 32'(live_cnt - lbase), 32'(vecs[i].pulses));
            if (vecs[i].pulses > 0 && live_cnt > lbase) begin
                check($sformatf("vec%0d sel", i),   32'(live_log[lbase][6:4]), 32'(vecs[i].sel));
                check($sformatf("vec%0d digit", i), 32'(live_log[lbase][3:0]), 32'(vecs[i].digit));
                check($sformatf("vec%0d bad", i),   32'(last_bad),             32'(vecs[i].bad));
            end
            check($sformatf("vec%0d state", i), 32'(dut.state), 32'(WAIT_SEL));
        end
        check("no frame with digit_en 0", 32'(frame_cnt - fbase), 32'd0);

        // Two-digit frame
        do_reset();
        digit_en = 8'h03;
        lbase = live_cnt;
        fbase = frame_cnt;
        drive(8'hfe, 7'b0011001, 6);
        drive(8'hfd, 7'b0100100, 6);
        drive(8'hff, 7'h7f, 4);
        #1;
        check("frame live pulses", 32'(live_cnt - lbase), 32'd2);
        if (live_cnt - lbase == 2) begin
            check("frame live 0", 32'(live_log[lbase]),     32'h04);
            check("frame live 1", 32'(live_log[lbase + 1]), 32'h12);
        end
        check("frame count",  32'(frame_cnt - fbase), 32'd1);
        check("frame digits", last_frame_digits,      32'h00000024);
        check("frame bad",    32'(last_frame_bad),    32'd0);
        drive(8'hff, 7'h7f, 5);
        check("frame digits hold", frame_digits, 32'h00000024);

        // Digit outside the mask is captured but does not complete the frame
        do_reset();
        digit_en = 8'h01;
        fbase = frame_cnt;
        drive(8'hfd, 7'b1111000, 6);
        drive(8'hff, 7'h7f, 3);
        #1;
        check("outside mask no frame", 32'(frame_cnt - fbase), 32'd0);
        drive(8'hfe, 7'b0010000, 6);
        drive(8'hff, 7'h7f, 4);
        #1;
        check("masked frame count",  32'(frame_cnt - fbase), 32'd1);
        check("masked frame digits", last_frame_digits,      32'h00000079);

        // Reset mid-settle discards the partial count
        do_reset();
        lbase = live_cnt;
        drive(8'hfe, 7'b0011001, 3);
        rst = 1'b1;
        drive(8'hfe, 7'b0011001, 1);
        rst = 1'b0;
        drive(8'hfe, 7'b0011001, 2);
        drive(8'hff, 7'h7f, 4);
        #1;
        check("mid-settle reset no pulse", 32'(live_cnt - lbase), 32'd0);

        // Reset mid-frame, then only digit 1
        do_reset();
        digit_en = 8'h03;
        fbase = frame_cnt;
        drive(8'hfe, 7'b0011001, 6);
        rst = 1'b1;
        drive(8'hff, 7'h7f, 1);
        rst = 1'b0;
        drive(8'hfd, 7'b0100100, 8);
        drive(8'hff, 7'h7f, 4);
        #1;
        check("mid-frame reset no frame", 32'(frame_cnt - fbase), 32'd0);
        check_all_zero("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
